// File: rtl/ccg_bist_wrapper.sv
// Self-test harness for a generated combinational circuit: LFSR pattern source, MISR response
// compactor and golden-signature compare, sequenced by a small run/drain FSM.
module ccg_bist_wrapper #(
  parameter int unsigned           NUM_IN    = 21,
  parameter int unsigned           NUM_OUT   = 14,
  parameter logic [NUM_IN-1:0]     LFSR_POLY = 21'h140000,
  parameter logic [NUM_OUT-1:0]    MISR_POLY = 14'h3802,
  parameter int unsigned           DUT_LAT   = 0,
  parameter int unsigned           CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_IN-1:0]  seed,
  input  logic [CNT_W-1:0]   num_patterns,
  input  logic [NUM_OUT-1:0] golden,
  output logic [NUM_IN-1:0]  pat_out,
  output logic               pat_valid,
  input  logic [NUM_OUT-1:0] resp_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_OUT-1:0] signature
);

  // One spare stage keeps the pipe legal when DUT_LAT is 0; it is never used then.
  localparam int unsigned PipeW = (DUT_LAT > 0) ? DUT_LAT : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [NUM_IN-1:0]  lfsr_q, lfsr_d, lfsr_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_OUT-1:0] golden_q, golden_d;
  logic [NUM_OUT-1:0] misr_q, misr_d, misr_upd;
  logic               pass_q, pass_d;
  logic [PipeW-1:0]   pipe_q, pipe_d;
  logic               resp_valid;

  assign pat_valid = (state_q == StRun);
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign pat_out   = lfsr_q;
  assign signature = misr_q;

  assign resp_valid = (DUT_LAT == 0) ? pat_valid : pipe_q[PipeW-1];
  assign lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);
  assign misr_upd   = resp_valid ? ((misr_q >> 1) ^ (misr_q[0] ? MISR_POLY : '0) ^ resp_in)
                                 : misr_q;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    golden_d = golden_q;
    misr_d   = misr_upd;
    pass_d   = pass_q;
    pipe_d   = (DUT_LAT == 0) ? '0 : ((pipe_q << 1) | PipeW'(pat_valid));

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lfsr_d   = (seed == '0) ? NUM_IN'(1) : seed;
          cnt_d    = num_patterns;
          golden_d = golden;
          misr_d   = '0;
          pipe_d   = '0;
          if (num_patterns == '0) begin
            state_d = StDone;
            pass_d  = (golden == '0);
          end else begin
            state_d = StRun;
            pass_d  = 1'b0;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          misr_d  = misr_q;
          pipe_d  = '0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            // Last pattern: hold the LFSR so pat_out keeps this vector through DRAIN.
            if (DUT_LAT == 0) begin
              state_d = StDone;
              pass_d  = (misr_upd == golden_q);
            end else begin
              state_d = StDrain;
            end
          end else begin
            lfsr_d = lfsr_step;
          end
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StIdle;
          misr_d  = misr_q;
          pipe_d  = '0;
          pass_d  = 1'b0;
        end else if (pipe_d == '0) begin
          state_d = StDone;
          pass_d  = (misr_upd == golden_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      golden_q <= '0;
      misr_q   <= '0;
      pass_q   <= 1'b0;
      pipe_q   <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      golden_q <= golden_d;
      misr_q   <= misr_d;
      pass_q   <= pass_d;
      pipe_q   <= pipe_d;
    end
  end

endmodule

// File: doc/ccg_bist_wrapper.md
Name: ccg_bist_wrapper

Overview:
- Parametrised self-test harness for generated combinational benchmark circuits (NUM_IN inputs, NUM_OUT outputs).
- Drives pseudo-random input vectors from an internal Galois LFSR and compacts the circuit's responses in a MISR.
- Compares the final signature against a golden value.
- Sits between the dataset testbench/controller and one generated combinational circuit.

Parameters:
- NUM_IN, 21, DUT input width and LFSR width (>=2)
- NUM_OUT, 14, DUT output width and MISR width (>=2)
- LFSR_POLY, 21'h140000, Galois feedback mask for the LFSR (NUM_IN bits)
- MISR_POLY, 14'h3802, Galois feedback mask for the MISR (NUM_OUT bits)
- DUT_LAT, 0, response latency in cycles from pat_out to resp_in (0..4)
- CNT_W, 16, width of the pattern counter

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run when IDLE or DONE
- abort  in  1  one-cycle pulse; terminates run
- seed  in  NUM_IN  LFSR seed, sampled on accepted start
- num_patterns  in  CNT_W  patterns to apply, sampled on accepted start
- golden  in  NUM_OUT  expected signature, sampled on accepted start
- pat_out  out  NUM_IN  vector driven to the DUT inputs
- pat_valid  out  1  pat_out is a counted pattern this cycle
- resp_in  in  NUM_OUT  DUT outputs
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- pass  out  1  valid while done; signature == golden
- signature  out  NUM_OUT  current MISR contents

Behaviour:
- Reset values: state IDLE; pat_out=0; pat_valid=0; busy=0; done=0; pass=0; signature=0; internal counter=0; valid pipe=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start:
  - Load LFSR from seed. A seed of 0 is replaced by 1.
  - Load counter with num_patterns; latch golden; clear MISR to 0; clear pass.
  - Go to RUN if num_patterns != 0, else DONE next cycle with signature=0.
- RUN, each cycle:
  - pat_out = LFSR; pat_valid=1.
  - LFSR next = (L>>1) ^ (L[0] ? LFSR_POLY : 0).
  - Counter decrements.
  - When the counter reaches 1 in RUN, the next state is DRAIN. Exactly num_patterns patterns are issued.
- Valid pipe:
  - pat_valid is delayed DUT_LAT cycles to give resp_valid. DUT_LAT=0 means same cycle; the DUT is combinational.
  - On resp_valid, MISR next = ((M>>1) ^ (M[0] ? MISR_POLY : 0)) ^ resp_in.
- DRAIN:
  - pat_valid=0; pat_out holds its last value.
  - Stay until the valid pipe is empty. Duration is DUT_LAT cycles; DRAIN is skipped straight to DONE if DUT_LAT=0.
- DONE:
  - done=1; pass = (MISR == golden latched), registered on entry.
  - Signature is held until the next start.
- abort in RUN/DRAIN:
  - Next state IDLE; pat_valid=0; pending responses are discarded.
  - Signature keeps its partial value; done=0; pass=0.
- start while busy is ignored.
- start and abort in the same cycle: abort wins if busy; start wins if IDLE/DONE.
- Asynchronous reset mid-run returns all state to reset values immediately. No partial output glitches beyond the async clear.
- Counter arithmetic is unsigned CNT_W-bit. num_patterns = 2^CNT_W-1 must complete without wrap.
- Latency from start to first pat_valid: 1 cycle.
- Latency from start to done: num_patterns + DUT_LAT + 1 cycles. The num_patterns=0 case is a 1-cycle latency.

Test Plan:
- Defaults, seed=1, num_patterns=2, resp_in tied 0 -> pat_out 21'h000001 then 21'h140000; done after 3 cycles; signature=0; pass=1 with golden=0.
- Defaults, seed=1, num_patterns=1, resp_in=14'h0001 -> signature=14'h0001; pass=0 when golden=0; pass=1 when golden=14'h0001.
- num_patterns=0 -> no pat_valid; done one cycle after start; signature=0.
- Seed=0 -> first pat_out=21'h000001 (substitution).
- DUT_LAT=2, num_patterns=3, resp_in counting 1,2,3 aligned to the delayed valids -> busy for 5 cycles; exactly three MISR updates; result matches the reference model.
- Abort on the 2nd RUN cycle, then start again -> IDLE, done=0; the new run restarts cleanly from the seed with MISR=0.
- Assert rst_n low mid-RUN -> all outputs 0 asynchronously; after release, state is IDLE.
- Start pulsed while busy -> ignored; the pattern count is unchanged.
